// File: rtl/fpaddsub_pkg.sv
// fpaddsub_pkg: flag bit positions, operation encoding and FP add/sub pipeline depth.
package fpaddsub_pkg;
    localparam int FLAG_OVF = 4;
    localparam int FLAG_UNF = 3;
    localparam int FLAG_DBZ = 2;
    localparam int FLAG_INV = 1;
    localparam int FLAG_INX = 0;
    localparam int FPADDSUB_LATENCY = 11;
    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} fp_op_e;
endpackage

// File: rtl/fpaddsub_rr_arbiter.sv
// fpaddsub_rr_arbiter: combinational round-robin pick, search starts at ptr+1 and wraps.
module fpaddsub_rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        grant = '0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (elig[W'((int'(ptr) + k) % N)]) begin
                grant = N'(1) << ((int'(ptr) + k) % N);
                idx = W'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/fpaddsub_issue_arbiter.sv
// fpaddsub_issue_arbiter: shares one fixed-latency FP add/sub unit among NUM_REQ requesters.
// Optional per-requester sticky flag registers under FPARB_STICKY_FLAGS_EN.
module fpaddsub_issue_arbiter
    import fpaddsub_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FPU_LATENCY = FPADDSUB_LATENCY,
    parameter int MAX_OUTST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_op,
    output logic [31:0]             fpu_a,
    output logic [31:0]             fpu_b,
    output logic                    fpu_ctrl,
    input  logic [31:0]             fpu_z,
    input  logic [4:0]              fpu_flags,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_z,
    output logic [4:0]              rsp_flags,
`ifdef FPARB_STICKY_FLAGS_EN
    output logic [5*NUM_REQ-1:0]    sticky_flags,
    input  logic [NUM_REQ-1:0]      sticky_clr,
`endif
    output logic                    idle
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic [NUM_REQ-1:0][CW-1:0]     credit;
    logic [NUM_REQ-1:0]             elig, grant;
    logic [IW-1:0]                  gidx, ptr, rid;
    logic                           xfer, rv;
    logic [FPU_LATENCY-1:0]         tag_v;
    logic [FPU_LATENCY-1:0][IW-1:0] tag_id;

    // Nothing is accepted while reset is asserted, so no operation can slip past the flush.
    always_comb
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_valid[i] && credit[i] != '0 && enable && !rst;

    fpaddsub_rr_arbiter #(.N(NUM_REQ), .W(IW)) u_arb (
        .elig  (elig),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    assign xfer      = |grant;
    assign req_ready = grant;
    assign fpu_a     = xfer ? req_a[32*gidx +: 32] : '0;
    assign fpu_b     = xfer ? req_b[32*gidx +: 32] : '0;
    assign fpu_ctrl  = xfer & req_op[gidx];

    // The FPU pipeline is never cleared; only the tag valids decide what reaches requesters.
    assign rv        = tag_v[FPU_LATENCY-1] && !rst;
    assign rid       = tag_id[FPU_LATENCY-1];
    assign rsp_valid = rv ? NUM_REQ'(1) << rid : '0;
    assign rsp_z     = rv ? fpu_z : '0;
    assign rsp_flags = rv ? fpu_flags : '0;
    assign idle      = rst || (tag_v == '0 && !xfer);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IW'(NUM_REQ - 1);
            tag_v <= '0;
            for (int i = 0; i < NUM_REQ; i++) credit[i] <= CW'(MAX_OUTST);
        end else begin
            ptr <= xfer ? gidx : ptr;
            tag_v <= {tag_v[FPU_LATENCY-2:0], xfer};
            for (int i = 0; i < NUM_REQ; i++)
                credit[i] <= credit[i] + CW'(rsp_valid[i]) - CW'(grant[i]);
        end
    end

    always_ff @(posedge clk)
        tag_id <= {tag_id[FPU_LATENCY-2:0], gidx};

`ifdef FPARB_STICKY_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst)
            sticky_flags <= '0;
        else
            for (int i = 0; i < NUM_REQ; i++)
                sticky_flags[5*i +: 5] <= (sticky_clr[i] ? 5'd0 : sticky_flags[5*i +: 5])
                                        | (rsp_valid[i] ? rsp_flags : 5'd0);
    end
`endif
endmodule

// File: tb/tb_fpaddsub_issue_arbiter.sv
// tb_fpaddsub_issue_arbiter: randomized bench with a stand-in fixed-latency FPU and a
// queue-based model of arbitration, credits and response routing.
module tb_fpaddsub_issue_arbiter;
    import fpaddsub_pkg::*;

    localparam int N = 4;
    localparam int L = 11;
    localparam int M = 4;

    logic           clk, rst, enable;
    logic [N-1:0]   req_valid, req_ready, req_op, rsp_valid;
    logic [32*N-1:0] req_a, req_b;
    logic [31:0]    fpu_a, fpu_b, fpu_z, rsp_z;
    logic           fpu_ctrl, idle;
    logic [4:0]     fpu_flags, rsp_flags;
`ifdef FPARB_STICKY_FLAGS_EN
    logic [5*N-1:0] sticky_flags;
    logic [N-1:0]   sticky_clr;
`endif

    fpaddsub_issue_arbiter #(.NUM_REQ(N), .FPU_LATENCY(L), .MAX_OUTST(M)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .fpu_a        (fpu_a),
        .fpu_b        (fpu_b),
        .fpu_ctrl     (fpu_ctrl),
        .fpu_z        (fpu_z),
        .fpu_flags    (fpu_flags),
        .rsp_valid    (rsp_valid),
        .rsp_z        (rsp_z),
        .rsp_flags    (rsp_flags),
`ifdef FPARB_STICKY_FLAGS_EN
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
`endif
        .idle         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in FPU: an integer function of the operands, so (0,0,add) yields nonzero garbage.
    function automatic logic [36:0] fpu_fn(logic [31:0] a, logic [31:0] b, logic op);
        logic [31:0] z;
        z = (op ? a - b : a + b) ^ 32'h5A5A_0001;
        return {z[4:0] ^ 5'h15, z};
    endfunction

    logic [31:0] pa [L];
    logic [31:0] pb [L];
    logic        pc [L];
    always @(posedge clk) begin
        pa[0] <= fpu_a;
        pb[0] <= fpu_b;
        pc[0] <= fpu_ctrl;
        for (int k = 1; k < L; k++) begin
            pa[k] <= pa[k-1];
            pb[k] <= pb[k-1];
            pc[k] <= pc[k-1];
        end
    end
    assign {fpu_flags, fpu_z} = fpu_fn(pa[L-1], pb[L-1], pc[L-1]);

    typedef struct {
        int          due;
        int          id;
        logic [31:0] z;
        logic [4:0]  f;
    } rsp_t;

    rsp_t        q[$];
    int          outst[N];
    int          mptr, cyc, gi, n_chk, n_fail;
    logic [N-1:0] erv;
    logic [31:0] ez;
    logic [4:0]  ef;
    logic [4:0]  st[N];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_check();
        logic [N-1:0] eg;
        eg = '0;
        gi = -1;
        if (!rst && enable)
            for (int k = 1; k <= N; k++) begin
                int j = (mptr + k) % N;
                if (gi < 0 && req_valid[j] && outst[j] < M) gi = j;
            end
        if (gi >= 0) eg[gi] = 1'b1;
        erv = '0;
        ez = '0;
        ef = '0;
        if (!rst && q.size() > 0 && q[0].due == cyc) begin
            erv[q[0].id] = 1'b1;
            ez = q[0].z;
            ef = q[0].f;
        end
        check("req_ready", 32'(req_ready), 32'(eg));
        check("rsp_valid", 32'(rsp_valid), 32'(erv));
        check("rsp_z", rsp_z, ez);
        check("rsp_flags", 32'(rsp_flags), 32'(ef));
        check("idle", 32'(idle), 32'(rst || (q.size() == 0 && gi < 0)));
        check("fpu_a", fpu_a, gi >= 0 ? req_a[32*gi +: 32] : 32'd0);
        check("fpu_b", fpu_b, gi >= 0 ? req_b[32*gi +: 32] : 32'd0);
        check("fpu_ctrl", 32'(fpu_ctrl), gi >= 0 ? 32'(req_op[gi]) : 32'd0);
`ifdef FPARB_STICKY_FLAGS_EN
        for (int i = 0; i < N; i++) check("sticky_flags", 32'(sticky_flags[5*i +: 5]), 32'(st[i]));
`endif
    endtask

    task automatic model_update();
        if (rst) begin
            q.delete();
            for (int i = 0; i < N; i++) begin
                outst[i] = 0;
                st[i] = '0;
            end
            mptr = N - 1;
        end else begin
`ifdef FPARB_STICKY_FLAGS_EN
            for (int i = 0; i < N; i++) st[i] = (sticky_clr[i] ? 5'd0 : st[i]) | (erv[i] ? ef : 5'd0);
`endif
            if (erv != '0) begin
                outst[q[0].id]--;
                void'(q.pop_front());
            end
            if (gi >= 0) begin
                logic [36:0] r;
                r = fpu_fn(req_a[32*gi +: 32], req_b[32*gi +: 32], req_op[gi]);
                outst[gi]++;
                mptr = gi;
                q.push_back('{due: cyc + L, id: gi, z: r[31:0], f: r[36:32]});
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_ops(int i, logic [31:0] a, logic [31:0] b, logic op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[i] = op;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        mptr = N - 1;
        for (int i = 0; i < N; i++) begin
            outst[i] = 0;
            st[i] = '0;
        end
        rst = 1'b1;
        enable = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
`ifdef FPARB_STICKY_FLAGS_EN
        sticky_clr = '0;
`endif
        repeat (3) step();
        rst = 1'b0;
        step();
        // single add from requester 0
        set_ops(0, 32'h3F80_0000, 32'h4000_0000, OP_ADD);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (14) step();
        // all requesters streaming distinct subtracts
        set_ops(0, 32'h4080_0000, 32'h3F80_0000, OP_SUB);
        set_ops(1, 32'h4040_0000, 32'h3F80_0000, OP_SUB);
        set_ops(2, 32'h40A0_0000, 32'h4000_0000, OP_SUB);
        set_ops(3, 32'h40C0_0000, 32'h4040_0000, OP_SUB);
        req_valid = '1;
        repeat (40) step();
        req_valid = '0;
        repeat (12) step();
        // credit exhaustion on requester 2
        req_valid = 4'b0100;
        repeat (30) step();
        req_valid = '0;
        repeat (12) step();
        // reset with operations in flight, then verify credits are restored
        req_valid = '1;
        repeat (5) step();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        repeat (20) step();
        req_valid = 4'b0100;
        repeat (6) step();
        req_valid = '0;
        repeat (12) step();
        // enable drop while requests are pending
        req_valid = 4'b0011;
        repeat (3) step();
        enable = 1'b0;
        repeat (15) step();
        enable = 1'b1;
        req_valid = '0;
        step();
        // randomized traffic
        repeat (500) begin
            rst = ($urandom_range(149) == 0);
            enable = ($urandom_range(9) != 0);
            req_valid = N'($urandom);
            req_op = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[32*i +: 32] = $urandom;
                req_b[32*i +: 32] = $urandom;
            end
`ifdef FPARB_STICKY_FLAGS_EN
            for (int i = 0; i < N; i++) sticky_clr[i] = ($urandom_range(7) == 0);
`endif
            step();
        end
        rst = 1'b0;
        enable = 1'b1;
        req_valid = '0;
`ifdef FPARB_STICKY_FLAGS_EN
        sticky_clr = '0;
`endif
        repeat (15) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
